// File: rtl/mac_os_tx_scheduler.sv
// Transmit ordered-set scheduler: TS1/TS2, SKP and idle onto the PHY lane.
// Ports: clk, reset_n, tx_en, os_sel, TS field inputs, ctr_clr -> txdata/txdatak/en_n, os_done, skp_pending, counters.
module mac_os_tx_scheduler #(
   parameter int SKP_INTERVAL = 1180,
   parameter int CTR_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tx_en,
   input  logic [1:0]       os_sel,
   input  logic [7:0]       link_num,
   input  logic             link_pad,
   input  logic [7:0]       lane_num,
   input  logic             lane_pad,
   input  logic [7:0]       n_fts,
   input  logic [7:0]       data_rate_id,
   input  logic [7:0]       train_ctrl,
   input  logic             ctr_clr,
   output logic [7:0]       txdata,
   output logic             txdatak,
   output logic             en_n,
   output logic             os_done,
   output logic             skp_pending,
   output logic [CTR_W-1:0] ts1_sent_ctr,
   output logic [CTR_W-1:0] ts2_sent_ctr
);

   localparam int TW = $clog2(SKP_INTERVAL);
   localparam logic [TW-1:0] T_LAST = TW'(SKP_INTERVAL - 1);
   localparam logic [7:0] COM     = 8'hBC;
   localparam logic [7:0] SKP_SYM = 8'h1C;
   localparam logic [7:0] PAD     = 8'hF7;
   localparam logic [7:0] TS1_ID  = 8'h4A;
   localparam logic [7:0] TS2_ID  = 8'h45;

   typedef enum logic [1:0] {OFF, IDL, TS, SKP} state_t;

   typedef struct packed {
      logic       ts2;
      logic       link_pad;
      logic [7:0] link;
      logic       lane_pad;
      logic [7:0] lane;
      logic [7:0] nfts;
      logic [7:0] dri;
      logic [7:0] tc;
   } snap_t;

   state_t        state, state_nxt;
   logic [3:0]    idx, idx_nxt;
   snap_t         snap, snap_nxt;
   logic [TW-1:0] timer;
   logic          bnd;
   logic [7:0]    data_nxt;
   logic          k_nxt, en_n_nxt, done_nxt;
   logic          ts1_end, ts2_end;

   // State and idx always describe the symbol currently on txdata.
   assign bnd = (state == OFF) || (state == IDL) ||
                (state == TS  && idx == 4'd15) ||
                (state == SKP && idx == 4'd3);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx + 4'd1;
      snap_nxt  = snap;
      if (bnd) begin
         idx_nxt  = 4'd0;
         snap_nxt = '{ts2: (os_sel == 2'b10),
                      link_pad: link_pad, link: link_num,
                      lane_pad: lane_pad, lane: lane_num,
                      nfts: n_fts, dri: data_rate_id,
                      tc: train_ctrl};
         if (!tx_en)
            state_nxt = OFF;
         else if (skp_pending)
            state_nxt = SKP;
         else if (os_sel == 2'b01 || os_sel == 2'b10)
            state_nxt = TS;
         else
            state_nxt = IDL;
      end
   end

   // Symbol for the next cycle, built from the next state so outputs are registered.
   always_comb begin
      data_nxt = 8'h00;
      k_nxt    = 1'b0;
      en_n_nxt = 1'b0;
      done_nxt = 1'b0;
      unique case (state_nxt)
         OFF: en_n_nxt = 1'b1;
         IDL: data_nxt = 8'h00;
         SKP: begin
            k_nxt    = 1'b1;
            data_nxt = (idx_nxt == 4'd0) ? COM : SKP_SYM;
            done_nxt = (idx_nxt == 4'd3);
         end
         TS: begin
            done_nxt = (idx_nxt == 4'd15);
            unique case (idx_nxt)
               4'd0: begin
                  data_nxt = COM;
                  k_nxt    = 1'b1;
               end
               4'd1: begin
                  data_nxt = snap_nxt.link_pad ? PAD : snap_nxt.link;
                  k_nxt    = snap_nxt.link_pad;
               end
               4'd2: begin
                  data_nxt = snap_nxt.lane_pad ? PAD : snap_nxt.lane;
                  k_nxt    = snap_nxt.lane_pad;
               end
               4'd3:    data_nxt = snap_nxt.nfts;
               4'd4:    data_nxt = snap_nxt.dri;
               4'd5:    data_nxt = snap_nxt.tc;
               default: data_nxt = snap_nxt.ts2 ? TS2_ID : TS1_ID;
            endcase
         end
         default: en_n_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= OFF;
         idx     <= 4'd0;
         snap    <= '0;
         txdata  <= 8'h00;
         txdatak <= 1'b0;
         en_n    <= 1'b1;
         os_done <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         snap    <= snap_nxt;
         txdata  <= data_nxt;
         txdatak <= k_nxt;
         en_n    <= en_n_nxt;
         os_done <= done_nxt;
      end
   end

   // Timer counts emitted symbols; the SKP start clears it and the request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer       <= '0;
         skp_pending <= 1'b0;
      end else if (state == SKP && idx == 4'd0) begin
         timer       <= '0;
         skp_pending <= 1'b0;
      end else if (!en_n) begin
         if (timer == T_LAST) begin
            timer       <= '0;
            skp_pending <= 1'b1;
         end else begin
            timer <= timer + TW'(1);
         end
      end
   end

   assign ts1_end = (state == TS) && (idx == 4'd15) && !snap.ts2;
   assign ts2_end = (state == TS) && (idx == 4'd15) &&  snap.ts2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts1_sent_ctr <= '0;
         ts2_sent_ctr <= '0;
      end else if (ctr_clr) begin
         ts1_sent_ctr <= '0;
         ts2_sent_ctr <= '0;
      end else begin
         if (ts1_end && ts1_sent_ctr != '1)
            ts1_sent_ctr <= ts1_sent_ctr + CTR_W'(1);
         if (ts2_end && ts2_sent_ctr != '1)
            ts2_sent_ctr <= ts2_sent_ctr + CTR_W'(1);
      end
   end

endmodule

// File: tb/tb_mac_os_tx_scheduler.sv
// Bench for mac_os_tx_scheduler: set-level reference model plus directed checks.
// Drives random fields/selects, compares every symbol and counter per cycle.
module tb_mac_os_tx_scheduler;

   localparam int INT = 20;
   localparam int CW  = 4;
   localparam int VW  = 12 + 2 * CW;
   localparam int K_OFF = 0;
   localparam int K_IDL = 1;
   localparam int K_TS1 = 2;
   localparam int K_TS2 = 3;
   localparam int K_SKP = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          tx_en = 1'b0;
   logic [1:0]    os_sel = 2'b00;
   logic [7:0]    link_num = 8'h00;
   logic          link_pad = 1'b0;
   logic [7:0]    lane_num = 8'h00;
   logic          lane_pad = 1'b0;
   logic [7:0]    n_fts = 8'h00;
   logic [7:0]    data_rate_id = 8'h00;
   logic [7:0]    train_ctrl = 8'h00;
   logic          ctr_clr = 1'b0;
   logic [7:0]    txdata;
   logic          txdatak;
   logic          en_n;
   logic          os_done;
   logic          skp_pending;
   logic [CW-1:0] ts1_sent_ctr;
   logic [CW-1:0] ts2_sent_ctr;

   mac_os_tx_scheduler #(.SKP_INTERVAL(INT), .CTR_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .os_sel(os_sel),
      .link_num(link_num), .link_pad(link_pad),
      .lane_num(lane_num), .lane_pad(lane_pad),
      .n_fts(n_fts), .data_rate_id(data_rate_id),
      .train_ctrl(train_ctrl), .ctr_clr(ctr_clr),
      .txdata(txdata), .txdatak(txdatak), .en_n(en_n),
      .os_done(os_done), .skp_pending(skp_pending),
      .ts1_sent_ctr(ts1_sent_ctr), .ts2_sent_ctr(ts2_sent_ctr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       k;
      logic       en_n;
      logic       done;
      int         kind;
      int         idx;
   } sym_t;

   sym_t          cur;
   sym_t          rest[$];
   int            mt;
   logic          mpend;
   logic [CW-1:0] mc1, mc2;
   int            checks = 0;
   int            errors = 0;
   logic [VW-1:0] rst_vec;

   function automatic sym_t mk(input logic [7:0] d, input logic k,
                               input logic off, input int kind,
                               input int idx);
      sym_t s;
      s.d    = d;
      s.k    = k;
      s.en_n = off;
      s.kind = kind;
      s.idx  = idx;
      s.done = ((kind == K_TS1 || kind == K_TS2) && idx == 15) ||
               (kind == K_SKP && idx == 3);
      return s;
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {txdata, txdatak, en_n, os_done, skp_pending,
              ts1_sent_ctr, ts2_sent_ctr};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {cur.d, cur.k, cur.en_n, cur.done, mpend, mc1, mc2};
   endfunction

   task automatic model_reset();
      cur = mk(8'h00, 1'b0, 1'b1, K_OFF, 0);
      rest.delete();
      mt    = 0;
      mpend = 1'b0;
      mc1   = '0;
      mc2   = '0;
   endtask

   // Whole-set generator: at a set boundary the next set is laid out at once.
   task automatic model_edge();
      logic       owed;
      logic [7:0] d;
      logic       k;
      int         kd;
      owed = mpend;
      if (!cur.en_n) begin
         if (cur.kind == K_SKP && cur.idx == 0) begin
            mt = 0;
            mpend = 1'b0;
         end else if (mt == INT - 1) begin
            mt = 0;
            mpend = 1'b1;
         end else begin
            mt++;
         end
      end
      if (ctr_clr) begin
         mc1 = '0;
         mc2 = '0;
      end else begin
         if (cur.kind == K_TS1 && cur.idx == 15 && mc1 < 4'hF) mc1++;
         if (cur.kind == K_TS2 && cur.idx == 15 && mc2 < 4'hF) mc2++;
      end
      if (rest.size() == 0) begin
         if (!tx_en) begin
            rest.push_back(mk(8'h00, 1'b0, 1'b1, K_OFF, 0));
         end else if (owed) begin
            for (int i = 0; i < 4; i++)
               rest.push_back(mk((i == 0) ? 8'hBC : 8'h1C, 1'b1, 1'b0, K_SKP, i));
         end else if (os_sel == 2'b01 || os_sel == 2'b10) begin
            kd = (os_sel == 2'b01) ? K_TS1 : K_TS2;
            for (int i = 0; i < 16; i++) begin
               k = 1'b0;
               case (i)
                  0: begin d = 8'hBC; k = 1'b1; end
                  1: begin d = link_pad ? 8'hF7 : link_num; k = link_pad; end
                  2: begin d = lane_pad ? 8'hF7 : lane_num; k = lane_pad; end
                  3: d = n_fts;
                  4: d = data_rate_id;
                  5: d = train_ctrl;
                  default: d = (kd == K_TS1) ? 8'h4A : 8'h45;
               endcase
               rest.push_back(mk(d, k, 1'b0, kd, i));
            end
         end else begin
            rest.push_back(mk(8'h00, 1'b0, 1'b0, K_IDL, 0));
         end
      end
      cur = rest.pop_front();
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_vec = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, {CW{1'b0}}, {CW{1'b0}}};
      #2 reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (dut_vec() !== rst_vec) begin
         errors++;
         $display("FAIL reset_vals got %h want %h", dut_vec(), rst_vec);
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_off got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_ts1_pad();
      logic [7:0] nf, dr, tc, wd;
      logic       wk;
      nf = 8'($urandom);
      dr = 8'($urandom);
      tc = 8'($urandom);
      n_fts = nf;
      data_rate_id = dr;
      train_ctrl = tc;
      link_num = 8'($urandom);
      lane_num = 8'($urandom);
      link_pad = 1'b1;
      lane_pad = 1'b1;
      os_sel = 2'b01;
      tx_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 2) begin
            n_fts = ~nf;
            train_ctrl = ~tc;
            link_pad = 1'b0;
            os_sel = 2'b11;
         end
         if (i == 10) begin
            n_fts = nf;
            train_ctrl = tc;
            link_pad = 1'b1;
            os_sel = 2'b01;
         end
         wk = 1'b0;
         case (i)
            0: begin wd = 8'hBC; wk = 1'b1; end
            1, 2: begin wd = 8'hF7; wk = 1'b1; end
            3: wd = nf;
            4: wd = dr;
            5: wd = tc;
            default: wd = 8'h4A;
         endcase
         checks++;
         if ({txdata, txdatak, os_done} !== {wd, wk, 1'(i == 15)}) begin
            errors++;
            $display("FAIL ts1_sym%0d got %h/%b want %h/%b",
                     i, txdata, txdatak, wd, wk);
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ts1_model got %h want %h", dut_vec(), exp_vec());
         end
      end
      tick();
      checks++;
      if ({ts1_sent_ctr, ts2_sent_ctr} !== {4'd1, 4'd0}) begin
         errors++;
         $display("FAIL ts1_ctr got %0d/%0d want 1/0",
                  ts1_sent_ctr, ts2_sent_ctr);
      end
   endtask

   // Second TS1 runs while the SKP request matures; TS2 is chosen mid-set.
   task automatic test_switch_skp();
      logic [7:0] lk, ln, wd;
      for (int j = 1; j < 16; j++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL sw_model got %h want %h", dut_vec(), exp_vec());
         end
         if (j == 3 || j == 4) begin
            checks++;
            if (skp_pending !== 1'(j == 4)) begin
               errors++;
               $display("FAIL skp_rise sym%0d got %b want %b",
                        16 + j, skp_pending, j == 4);
            end
         end
         if (j == 7) begin
            lk = 8'($urandom);
            ln = 8'($urandom);
            os_sel = 2'b10;
            link_pad = 1'b0;
            lane_pad = 1'b0;
            link_num = lk;
            lane_num = ln;
         end
      end
      checks++;
      if (txdata !== 8'h4A) begin
         errors++;
         $display("FAIL sw_ts1_tail got %h want 4a", txdata);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         wd = (i == 0) ? 8'hBC : 8'h1C;
         checks++;
         if ({txdata, txdatak, en_n, os_done} !== {wd, 1'b1, 1'b0, 1'(i == 3)}) begin
            errors++;
            $display("FAIL skp_sym%0d got %h/%b want %h/1", i, txdata, txdatak, wd);
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL skp_model got %h want %h", dut_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         case (i)
            0: wd = 8'hBC;
            1: wd = lk;
            2: wd = ln;
            3: wd = n_fts;
            4: wd = data_rate_id;
            5: wd = train_ctrl;
            default: wd = 8'h45;
         endcase
         checks++;
         if (txdata !== wd) begin
            errors++;
            $display("FAIL ts2_sym%0d got %h want %h", i, txdata, wd);
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ts2_model got %h want %h", dut_vec(), exp_vec());
         end
      end
      tick();
      checks++;
      if ({ts1_sent_ctr, ts2_sent_ctr} !== {4'd2, 4'd1}) begin
         errors++;
         $display("FAIL sw_ctrs got %0d/%0d want 2/1",
                  ts1_sent_ctr, ts2_sent_ctr);
      end
   endtask

   task automatic test_tx_off();
      int n = 0;
      os_sel = 2'b01;
      while (!(cur.kind == K_TS1 && cur.idx == 3) && n < 100) begin
         tick();
         n++;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL off_wait got %h want %h", dut_vec(), exp_vec());
         end
      end
      checks++;
      if (!(cur.kind == K_TS1 && cur.idx == 3)) begin
         errors++;
         $display("FAIL off_timeout got idx %0d want 3", cur.idx);
      end
      tx_en = 1'b0;
      for (int i = 4; i < 16; i++) begin
         tick();
         checks++;
         if (en_n !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL off_tail%0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      tick();
      checks++;
      if ({en_n, txdata} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL off_state got %b/%h want 1/00", en_n, txdata);
      end
      repeat (10) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL off_hold got %h want %h", dut_vec(), exp_vec());
         end
      end
      tx_en = 1'b1;
      repeat (60) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL off_resume got %h want %h", dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_saturate();
      int n = 0;
      os_sel = 2'b01;
      tx_en = 1'b1;
      while (mc1 != 4'hF && n < 800) begin
         tick();
         n++;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL sat_run got %h want %h", dut_vec(), exp_vec());
         end
      end
      for (int pass = 0; pass < 2; pass++) begin
         n = 0;
         while (!(cur.kind == K_TS1 && cur.idx == 15) && n < 60) begin
            tick();
            n++;
         end
         checks++;
         if (!(cur.kind == K_TS1 && cur.idx == 15)) begin
            errors++;
            $display("FAIL sat_timeout got idx %0d want 15", cur.idx);
         end
         ctr_clr = (pass == 1);
         tick();
         ctr_clr = 1'b0;
         checks++;
         if (pass == 0 && ts1_sent_ctr !== 4'hF) begin
            errors++;
            $display("FAIL sat_hold got %h want f", ts1_sent_ctr);
         end
         checks++;
         if (pass == 1 && {ts1_sent_ctr, ts2_sent_ctr} !== 8'h00) begin
            errors++;
            $display("FAIL clr_prio got %h/%h want 0/0",
                     ts1_sent_ctr, ts2_sent_ctr);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      os_sel = 2'b01;
      tx_en = 1'b1;
      while (!(cur.kind == K_TS1 && cur.idx == 9) && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (!(cur.kind == K_TS1 && cur.idx == 9)) begin
         errors++;
         $display("FAIL rmid_timeout got idx %0d want 9", cur.idx);
      end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== rst_vec) begin
         errors++;
         $display("FAIL rmid_async got %h want %h", dut_vec(), rst_vec);
      end
      model_reset();
      tick();
      tick();
      checks++;
      if (dut_vec() !== rst_vec) begin
         errors++;
         $display("FAIL rmid_hold got %h want %h", dut_vec(), rst_vec);
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if ({txdata, txdatak, en_n} !== {8'hBC, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rmid_fresh got %h/%b/%b want bc/1/0",
                  txdata, txdatak, en_n);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL rmid_model got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 900; c++) begin
         tx_en = ($urandom % 8) != 0;
         os_sel = 2'($urandom);
         link_pad = 1'($urandom);
         lane_pad = 1'($urandom);
         link_num = 8'($urandom);
         lane_num = 8'($urandom);
         n_fts = 8'($urandom);
         data_rate_id = 8'($urandom);
         train_ctrl = 8'($urandom);
         ctr_clr = ($urandom % 60) == 0;
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rand_c%0d got %h want %h", c, dut_vec(), exp_vec());
         end
      end
      ctr_clr = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ts1_pad();
      test_switch_skp();
      test_tx_off();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
